// File: rtl/fwd_prop_seq.sv
// rtl/fwd_prop_seq.sv - forward-propagation sequencer (9-in/5-hid/4-out); FWD_SEQ_UPD_EN adds the UPD phase
module fwd_prop_seq #(
    parameter int N_IN  = 9,
    parameter int N_HID = 5,
    parameter int N_OUT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       upd_req,
    output logic [3:0] ctrl,
    output logic [3:0] st,
    output logic [2:0] sel,
    output logic [3:0] step,
    output logic       acc_clr,
    output logic       busy,
    output logic       done
);

    localparam int n_out_unused = N_OUT;

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0000,
        S_L2MAC = 4'b0001,
        S_BIAS2 = 4'b0010,
        S_ACT2  = 4'b0011,
        S_L3MAC = 4'b0100,
        S_BIAS3 = 4'b0101,
        S_ACT3  = 4'b0110,
        S_DONE  = 4'b0111,
        S_UPD   = 4'b1000
    } state_t;

    state_t     state, state_nx;
    logic [3:0] st_nx, step_nx;
    logic [2:0] sel_nx;
    logic       acc_clr_nx;
    logic       upd_pend;

`ifdef FWD_SEQ_UPD_EN
    logic upd_latch, upd_latch_nx;
    assign upd_pend = upd_latch;
`else
    logic upd_unused;
    assign upd_unused = upd_req;
    assign upd_pend   = 1'b0;
`endif

    // Every output is a decode of, or a copy of, a register.
    assign ctrl     = state;
    assign in_ready = (state == S_L2MAC);
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);

    always_comb begin
        state_nx   = state;
        st_nx      = st;
        sel_nx     = sel;
        step_nx    = step;
        acc_clr_nx = 1'b0;
`ifdef FWD_SEQ_UPD_EN
        upd_latch_nx = upd_latch | upd_req;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx   = S_L2MAC;
                    acc_clr_nx = 1'b1;
                    st_nx      = 4'd0;
                    sel_nx     = 3'd0;
                end
            end
            S_L2MAC: begin
                if (in_valid && in_ready) begin
                    if (st == 4'(N_IN - 1)) state_nx = S_BIAS2;
                    else                    st_nx    = st + 4'd1;
                end
            end
            S_BIAS2: state_nx = S_ACT2;
            S_ACT2: begin
                state_nx = S_L3MAC;
                sel_nx   = 3'd0;
            end
            S_L3MAC: begin
                if (sel == 3'(N_HID - 1)) begin
                    state_nx = S_BIAS3;
                    sel_nx   = 3'd0;
                end else begin
                    sel_nx = sel + 3'd1;
                end
            end
            S_BIAS3: state_nx = S_ACT3;
            S_ACT3:  state_nx = upd_pend ? S_UPD : S_DONE;
            S_UPD: begin
                state_nx = S_DONE;
`ifdef FWD_SEQ_UPD_EN
                upd_latch_nx = upd_req;
`endif
            end
            S_DONE: begin
                state_nx = S_IDLE;
                // step=0 freezes the datapath, so the counter wraps 15 -> 1.
                step_nx  = (step == 4'd15) ? 4'd1 : step + 4'd1;
            end
            default: state_nx = S_IDLE;
        endcase

        if (abort && state != S_IDLE) begin
            state_nx   = S_IDLE;
            st_nx      = 4'd0;
            sel_nx     = 3'd0;
            step_nx    = step;
            acc_clr_nx = 1'b0;
`ifdef FWD_SEQ_UPD_EN
            upd_latch_nx = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            st      <= 4'd0;
            sel     <= 3'd0;
            step    <= 4'd1;
            acc_clr <= 1'b0;
        end else begin
            state   <= state_nx;
            st      <= st_nx;
            sel     <= sel_nx;
            step    <= step_nx;
            acc_clr <= acc_clr_nx;
        end
    end

`ifdef FWD_SEQ_UPD_EN
    always_ff @(posedge clk) begin
        if (!rst) upd_latch <= 1'b0;
        else      upd_latch <= upd_latch_nx;
    end
`endif

endmodule

// File: tb/tb_fwd_prop_seq.sv
// tb/tb_fwd_prop_seq.sv - scoreboard bench for fwd_prop_seq
module tb_fwd_prop_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       in_valid = 1'b0;
    logic       upd_req = 1'b0;
    logic       in_ready;
    logic [3:0] ctrl;
    logic [3:0] st;
    logic [2:0] sel;
    logic [3:0] step;
    logic       acc_clr;
    logic       busy;
    logic       done;

    fwd_prop_seq dut (
        .clk      (clk),
        .rst      (rst_n),
        .start    (start),
        .abort    (abort),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .upd_req  (upd_req),
        .ctrl     (ctrl),
        .st       (st),
        .sel      (sel),
        .step     (step),
        .acc_clr  (acc_clr),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int         cyc;
        logic [3:0] step;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [3:0] step_m = 4'd1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done @cyc %0d: got done=1, expected none", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("done_step", int'(step), int'(e.step));
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ctrl"}, int'(ctrl), 0);
        chk({tag, "_st"}, int'(st), 0);
        chk({tag, "_sel"}, int'(sel), 0);
        chk({tag, "_step"}, int'(step), 1);
        chk({tag, "_flags"}, int'({acc_clr, busy, done, in_ready}), 0);
    endtask

    // Caller is positioned at the negedge of cycle k; returns at the negedge
    // of the IDLE cycle after DONE, ready to launch the next pass.
    task automatic do_pass(input int stall_len, input bit upd, input bit mid_start);
        int k, len, st_e, stalls, l3;
        int ec[$];
        exp_t e;
        k = cyc;
        for (int i = 0; i < 9 + stall_len; i++) ec.push_back(1);
        ec.push_back(2);
        ec.push_back(3);
        for (int i = 0; i < 5; i++) ec.push_back(4);
        ec.push_back(5);
        ec.push_back(6);
        if (upd) ec.push_back(8);
        ec.push_back(7);
        ec.push_back(0);
        len = ec.size();
        e.cyc  = k + 19 + stall_len + (upd ? 1 : 0);
        e.step = step_m;
        exp_q.push_back(e);
        start    = 1'b1;
        abort    = 1'b0;
        in_valid = 1'b1;
        st_e = 0;
        stalls = 0;
        l3 = 0;
        for (int off = 1; off <= len; off++) begin
            @(negedge clk);
            start = (mid_start && off == 13);
            upd_req = (upd && off == 3);
            chk("ctrl", int'(ctrl), ec[off-1]);
            chk("in_ready", int'(in_ready), (ec[off-1] == 1) ? 1 : 0);
            if (off <= 2) chk("acc_clr", int'(acc_clr), (off == 1) ? 1 : 0);
            if (ec[off-1] == 1) begin
                chk("st", int'(st), st_e);
                in_valid = !(st_e == 4 && stalls < stall_len);
                if (!in_valid) stalls++;
                else if (st_e < 8) st_e++;
            end else begin
                in_valid = 1'b1;
            end
            if (ec[off-1] == 4) begin
                chk("sel", int'(sel), l3);
                l3++;
            end
        end
        step_m = (step_m == 4'd15) ? 4'd1 : step_m + 4'd1;
        chk("step_after", int'(step), int'(step_m));
        chk("busy_after", int'(busy), 0);
    endtask

    initial begin
        int k;
        // Reset state
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Nominal pass, then a pass with a 3-cycle stall at st=4
        do_pass(0, 1'b0, 1'b0);
        do_pass(3, 1'b0, 1'b0);

        // Abort at sel=2
        k = cyc;
        start = 1'b1;
        in_valid = 1'b1;
        for (int off = 1; off <= 14; off++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("abort_pre_sel", int'(sel), 2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_ctrl", int'(ctrl), 0);
        chk("abort_st_sel", int'({st, 1'b0, sel}), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_step", int'(step), int'(step_m));
        // Abort together with start in IDLE must not block the start
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        chk("abort_idle_start_busy", int'(busy), 1);
        abort = 1'b1;
        start = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        repeat (10) @(negedge clk);
        do_pass(0, 1'b0, 1'b0);

        // Start pulsed during L3MAC is ignored
        do_pass(0, 1'b0, 1'b1);
        repeat (22) @(negedge clk);
        chk("mid_start_idle", int'(busy), 0);

        // Reset during BIAS2
        k = cyc;
        start = 1'b1;
        for (int off = 1; off <= 10; off++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("bias2_ctrl", int'(ctrl), 2);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_vals("midreset");
        rst_n = 1'b1;
        step_m = 4'd1;
        @(negedge clk);

        // 15 back-to-back passes: step 2..15 then 1
        for (int p = 0; p < 15; p++) do_pass(0, 1'b0, 1'b0);
        chk("wrap_step", int'(step), 1);

`ifdef FWD_SEQ_UPD_EN
        do_pass(0, 1'b1, 1'b0);
        do_pass(0, 1'b0, 1'b0);
`endif

        repeat (25) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1);
    end

endmodule
